shift_unit: RTL

SHIFT_UNIT -- requirements
Module: shift_unit

---
 rtl/shift_unit_pkg.sv | 20 ++
 rtl/shift_unit.sv | 91 +++++++++
 2 files changed

// File: rtl/shift_unit_pkg.sv
// Shared types and constants for the iterative shift unit.
// Op encoding matches the upstream decoder; state type is used by shift_unit.
package shift_unit_pkg;

    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } shift_state_t;

endpackage

// File: rtl/shift_unit.sv
// Iterative one-bit-per-cycle shifter: SLL/SRL/SRA/ROR by shamt_in[4:0].
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for start; result holds the last operation value
// ST_SHIFT | one bit shifted per edge until the down-counter hits 0
// ST_DONE  | single-cycle completion, done asserted
module shift_unit
    import shift_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] data_in,
    input  logic [31:0] shamt_in,
    output logic [31:0] result,
    output logic        busy,
    output logic        done
);

    shift_state_t        state_q, state_d;
    shift_op_t           op_q, op_d;
    logic [31:0]         sreg_q, sreg_d;
    logic [SHAMT_W-1:0]  cnt_q, cnt_d;

    // Upper shift-amount bits are deliberately discarded; the count is mod 32.
    logic unused_shamt_hi;
    assign unused_shamt_hi = |shamt_in[31:SHAMT_W];

    function automatic logic [31:0] shift_one(input shift_op_t op_sel, input logic [31:0] v);
        shift_one = v;
        case (op_sel)
            OP_SLL: shift_one = {v[30:0], 1'b0};
            OP_SRL: shift_one = {1'b0, v[31:1]};
            OP_SRA: shift_one = {v[31], v[31:1]};
            OP_ROR: shift_one = {v[0], v[31:1]};
            default: shift_one = v;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_SLL;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sreg_d  = data_in;
                    cnt_d   = shamt_in[SHAMT_W-1:0];
                    op_d    = shift_op_t'(op);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != '0) begin
                    sreg_d = shift_one(op_q, sreg_q);
                    cnt_d  = cnt_q - SHAMT_W'(1);
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign result = sreg_q;
    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);

endmodule
